// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: queues 3-byte SPI command frames in a small FIFO and
// arbitrates them round-robin against a local requester for a shared
// 7-bit address / 16-bit data register bus. Only one bus transaction is
// outstanding at a time. Each completion, with its read data, goes back to
// the side that issued the command.
// Optional feature: define SPI_CMD_TIMEOUT_EN to compile in the WAIT
// timeout counter. Without it, WAIT exits only on bus_ack.
module spi_cmd_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic [23:0]            frame_in,
  input  logic                   frame_valid,
  input  logic                   loc_req,
  input  logic                   loc_we,
  input  logic [6:0]             loc_addr,
  input  logic [15:0]            loc_wdata,
  output logic                   loc_done,
  output logic [15:0]            loc_rdata,
  output logic                   spi_rsp_valid,
  output logic [15:0]            spi_rsp_data,
  output logic                   rsp_err,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [6:0]             bus_addr,
  output logic [15:0]            bus_wdata,
  input  logic                   bus_ack,
  input  logic [15:0]            bus_rdata,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Same bit layout as an SPI frame, so a frame casts straight into a command.
  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          cmd_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop, drop;
  logic          gnt_spi, gnt_loc;
  logic          last_loc, src_loc, abort_q, abort_evt;
  logic [15:0]   rdata_q;

  assign full = (fifo_level == LW'(DEPTH));

  // Round-robin grant in IDLE: on a tie, serve the side that was not served last.
  always_comb begin
    gnt_spi = 1'b0;
    gnt_loc = 1'b0;
    if (state == IDLE) begin
      gnt_spi = (fifo_level != '0) && (!loc_req || last_loc);
      gnt_loc = loc_req && !gnt_spi;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign pop  = gnt_spi;
  assign push = frame_valid && (!full || pop);
  assign drop = frame_valid && full && !pop;

  // FIFO storage. Validity is tracked only by the pointers, so there is no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'(frame_in);
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] timer;

  // Count WAIT cycles. An ack arriving on the last allowed cycle wins over the abort.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)            timer <= '0;
    else if (state != WAIT)  timer <= '0;
    else                     timer <= timer + 16'd1;
  end

  assign abort_evt = (state == WAIT) && (timer == TMO_LAST) && !bus_ack;

  // Sticky timeout flag. A new abort takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) timeout_err <= 1'b0;
    else          timeout_err <= (timeout_err && !err_clr) || abort_evt;
  end
`else
  assign abort_evt   = 1'b0;
  assign timeout_err = 1'b0;
  // TIMEOUT has no effect when the counter is not built.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // Sticky overflow flag. A drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) overflow <= 1'b0;
    else          overflow <= (overflow && !err_clr) || drop;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_spi || gnt_loc)   state_nxt = WAIT;
      WAIT:    if (bus_ack || abort_evt) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted command and record its source; capture read data or the abort result.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cmd_q    <= '0;
      src_loc  <= 1'b0;
      last_loc <= 1'b1;
      rdata_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      if (gnt_spi) begin
        cmd_q    <= mem[rd_ptr];
        src_loc  <= 1'b0;
        last_loc <= 1'b0;
        abort_q  <= 1'b0;
      end else if (gnt_loc) begin
        cmd_q    <= {loc_we, loc_addr, loc_wdata};
        src_loc  <= 1'b1;
        last_loc <= 1'b1;
        abort_q  <= 1'b0;
      end
      if (state == WAIT) begin
        if (bus_ack) begin
          rdata_q <= bus_rdata;
        end else if (abort_evt) begin
          rdata_q <= 16'hFFFF;
          abort_q <= 1'b1;
        end
      end
    end
  end

  // FSM outputs: request while in WAIT; pulse the completion to its source in RESP.
  always_comb begin
    bus_req       = (state == WAIT);
    loc_done      = (state == RESP) && src_loc;
    spi_rsp_valid = (state == RESP) && !src_loc;
    rsp_err       = (state == RESP) && abort_q;
  end

  assign bus_we       = cmd_q.we;
  assign bus_addr     = cmd_q.addr;
  assign bus_wdata    = cmd_q.wdata;
  assign loc_rdata    = rdata_q;
  assign spi_rsp_data = rdata_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Bench for spi_cmd_arbiter. Directed scenarios are followed by random traffic.
// Every cycle is checked against a transaction-level reference model that
// keeps a queue of frames, the outstanding command and any pending completion.
module tb_spi_cmd_arbiter;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
`ifdef SPI_CMD_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk, reset_N;
  logic [23:0] frame_in;
  logic        frame_valid, loc_req, loc_we;
  logic [6:0]  loc_addr;
  logic [15:0] loc_wdata;
  logic        loc_done, spi_rsp_valid, rsp_err;
  logic [15:0] loc_rdata, spi_rsp_data;
  logic        bus_req, bus_we, bus_ack;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic [2:0]  fifo_level;
  logic        overflow, timeout_err, err_clr;

  spi_cmd_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_N(reset_N), .frame_in(frame_in), .frame_valid(frame_valid),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_done(loc_done), .loc_rdata(loc_rdata), .spi_rsp_valid(spi_rsp_valid),
    .spi_rsp_data(spi_rsp_data), .rsp_err(rsp_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .fifo_level(fifo_level), .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit [23:0]   mq[$];
  bit          c_vld, c_loc, c_we;
  bit [6:0]    c_addr;
  bit [15:0]   c_wd;
  int          c_age;
  bit          r_vld, r_loc, r_we, r_err;
  bit [15:0]   r_data;
  bit          m_last_loc, m_ovf, m_tmo;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    c_vld = 0; c_age = 0; r_vld = 0; r_err = 0;
    m_last_loc = 1; m_ovf = 0; m_tmo = 0;
  endtask

  // Advance the model by one clock, using the inputs currently driven.
  task automatic model_step();
    int lvl;
    bit popped, set_ovf, set_tmo;
    bit [23:0] f;
    lvl = mq.size(); popped = 0; set_ovf = 0; set_tmo = 0;
    if (r_vld) begin
      r_vld = 0;
    end else if (c_vld) begin
      if (bus_ack) begin
        r_vld = 1; r_loc = c_loc; r_we = c_we; r_data = bus_rdata; r_err = 0; c_vld = 0;
      end else if (TMO_ON && c_age + 1 == TMO) begin
        r_vld = 1; r_loc = c_loc; r_we = c_we; r_data = 16'hFFFF; r_err = 1; c_vld = 0;
        set_tmo = 1;
      end else begin
        c_age++;
      end
    end else if (lvl > 0 && (!loc_req || m_last_loc)) begin
      f = mq.pop_front(); popped = 1;
      c_vld = 1; c_loc = 0; c_we = f[23]; c_addr = f[22:16]; c_wd = f[15:0]; c_age = 0;
      m_last_loc = 0;
    end else if (loc_req) begin
      c_vld = 1; c_loc = 1; c_we = loc_we; c_addr = loc_addr; c_wd = loc_wdata; c_age = 0;
      m_last_loc = 1;
    end
    if (frame_valid) begin
      if (lvl < DEPTH || popped) mq.push_back(frame_in);
      else set_ovf = 1;
    end
    if (err_clr) begin m_ovf = 0; m_tmo = 0; end
    m_ovf = m_ovf | set_ovf;
    m_tmo = m_tmo | set_tmo;
  endtask

  task automatic compare();
    chk("bus_req", bus_req, c_vld);
    if (c_vld) begin
      chk("bus_we", bus_we, c_we);
      chk("bus_addr", bus_addr, c_addr);
      chk("bus_wdata", bus_wdata, c_wd);
    end
    chk("loc_done", loc_done, r_vld && r_loc);
    chk("spi_rsp_valid", spi_rsp_valid, r_vld && !r_loc);
    chk("rsp_err", rsp_err, r_vld && r_err);
    if (r_vld && !r_we) chk("rsp_rdata", r_loc ? loc_rdata : spi_rsp_data, r_data);
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("timeout_err", timeout_err, m_tmo);
  endtask

  // One clock: model and DUT advance together, then outputs are compared at the falling edge.
  // Strobes are cleared afterwards, and loc_req is dropped after a loc_done.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    frame_valid = 0; bus_ack = 0; err_clr = 0;
    if (loc_done) loc_req = 0;
  endtask

  task automatic apply_reset();
    reset_N = 0;
    frame_valid = 0; loc_req = 0; bus_ack = 0; err_clr = 0;
    #1;
    model_reset();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_loc_done", loc_done, 0);
    chk("rst_spi_rsp", spi_rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_bus_cmd", {bus_we, bus_addr, bus_wdata}, 0);
    chk("rst_rdata", {loc_rdata, spi_rsp_data}, 0);
    chk("rst_flags", {overflow, timeout_err}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_N = 1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      if (bus_req) bus_ack = 1;
      step();
    end
  endtask

  initial begin
    logic [6:0] rr_exp [4];
    logic [6:0] grants [$];
    bit prev_req;
    int cnt, k;

    clk = 0; reset_N = 1;
    frame_in = 0; frame_valid = 0; loc_req = 0; loc_we = 0; loc_addr = 0; loc_wdata = 0;
    bus_ack = 0; bus_rdata = 0; err_clr = 0;
    #2;
    apply_reset();

    // single SPI write: request two cycles after the frame strobe
    frame_in = 24'h85_1234; frame_valid = 1;
    step();
    chk("wr_lat_t1", bus_req, 0);
    step();
    chk("wr_lat_t2", bus_req, 1);
    chk("wr_cmd", {bus_we, bus_addr, bus_wdata}, {1'b1, 7'h05, 16'h1234});
    bus_ack = 1; bus_rdata = 16'h0000;
    step();
    chk("wr_rsp", {spi_rsp_valid, rsp_err, bus_req}, 3'b100);
    step();

    // SPI read returns the acknowledged data
    frame_in = 24'h0A_0000; frame_valid = 1;
    step(); step();
    chk("rd_cmd", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 7'h0A});
    bus_ack = 1; bus_rdata = 16'hBEEF;
    step();
    chk("rd_data", {spi_rsp_valid, spi_rsp_data}, {1'b1, 16'hBEEF});
    step();

    // round robin: local occupies the bus while three frames queue up
    loc_req = 1; loc_we = 0; loc_addr = 7'h40; loc_wdata = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      frame_in = {1'b1, 7'(8'h10 + i), 16'(i)}; frame_valid = 1;
      step();
    end
    bus_ack = 1;
    step();
    step();
    loc_req = 1; loc_we = 1; loc_addr = 7'h41; loc_wdata = 16'h5A5A;
    rr_exp[0] = 7'h10; rr_exp[1] = 7'h41; rr_exp[2] = 7'h11; rr_exp[3] = 7'h12;
    prev_req = 0; k = 0;
    while (grants.size() < 4 && k < 60) begin
      if (bus_req && !prev_req) grants.push_back(bus_addr);
      prev_req = bus_req;
      if (bus_req) bus_ack = 1;
      step();
      k++;
    end
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < grants.size()) ? grants[i] : 7'h7F, rr_exp[i]);
    drain(12);

    // overflow: five frames arrive while the bus is stalled
    loc_req = 1; loc_we = 1; loc_addr = 7'h42; loc_wdata = 16'h1111;
    step();
    chk("loc_lat", bus_req, 1);
    for (int i = 0; i < 5; i++) begin
      frame_in = {1'b0, 7'(8'h20 + i), 16'h0}; frame_valid = 1;
      step();
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    bus_ack = 1;
    step(); step(); step();
    chk("ovf_sticky", overflow, 1);
    err_clr = 1;
    step();
    chk("ovf_clr", overflow, 0);
    drain(24);

    // timeout behaviour
`ifdef SPI_CMD_TIMEOUT_EN
    loc_req = 1; loc_we = 0; loc_addr = 7'h33; loc_wdata = 0;
    step();
    cnt = 0; k = 0;
    while (!loc_done && k < 20) begin cnt += int'(bus_req); step(); k++; end
    chk("tmo_req_cycles", cnt, TMO);
    chk("tmo_done", {loc_done, rsp_err}, 2'b11);
    chk("tmo_rdata", loc_rdata, 16'hFFFF);
    chk("tmo_sticky", timeout_err, 1);
    step();
    err_clr = 1;
    step();
    loc_req = 1; loc_we = 0; loc_addr = 7'h34;
    step();
    cnt = 0; k = 0;
    while (!loc_done && k < 20) begin
      cnt += int'(bus_req);
      if (bus_req && cnt == TMO) begin bus_ack = 1; bus_rdata = 16'h1357; end
      step();
      k++;
    end
    chk("ack_last_cycles", cnt, TMO);
    chk("ack_last_done", {loc_done, rsp_err, timeout_err}, 3'b100);
    chk("ack_last_rdata", loc_rdata, 16'h1357);
    step();
`else
    loc_req = 1; loc_we = 0; loc_addr = 7'h33; loc_wdata = 0;
    step();
    repeat (20) step();
    chk("no_tmo_req", bus_req, 1);
    chk("no_tmo_flag", timeout_err, 0);
    bus_ack = 1; bus_rdata = 16'h2468;
    step();
    chk("no_tmo_done", {loc_done, rsp_err}, 2'b10);
    chk("no_tmo_rdata", loc_rdata, 16'h2468);
    step();
`endif

    // reset while a transaction is outstanding and frames are queued
    loc_req = 1; loc_we = 1; loc_addr = 7'h50; loc_wdata = 16'hAAAA;
    step();
    for (int i = 0; i < 2; i++) begin
      frame_in = {1'b1, 7'(8'h60 + i), 16'h0}; frame_valid = 1;
      step();
    end
    chk("pre_rst_level", fifo_level, 2);
    apply_reset();
    repeat (4) step();

    // random traffic against the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      frame_valid = ($urandom_range(0, 2) == 0);
      frame_in    = 24'($urandom());
      if (!loc_req && !loc_done && $urandom_range(0, 3) == 0) begin
        loc_req   = 1;
        loc_we    = 1'($urandom_range(0, 1));
        loc_addr  = 7'($urandom());
        loc_wdata = 16'($urandom());
      end
      bus_ack   = bus_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      bus_rdata = 16'($urandom());
      err_clr   = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
